gamepad_reader_multi: RTL and testbench
=======================================

// Module: gamepad_reader_multi
// PURPOSE
//  Serial gamepad controller for vdp_lite, covering N pads on one shared latch/clock.
//  Pulses pad_latch, then clocks BITS bits out of each pad's shift register.
//  Publishes a per-pad button word plus sticky newly-pressed flags, on demand or auto-polled.
//  Sits between the GAMEPAD mprj_io pins and the CPU register file.
// PARAMETERS
//  PADS          2     number of pads (pad_data width); 1..4
//  BITS          12    bits shifted per pad per scan; 1..16
//  HALF_PERIOD   4     clk cycles per pad_clk phase; >= 4
//  POLL_INTERVAL 0     idle cycles between auto scans; 0 disables auto-poll
//  INVERT        0     1: pad lines active-low, stored data inverted
// PORTS
//  clk            in   1          system clock
//  resetb         in   1          asynchronous reset, active-low
//  start          in   1          1-cycle scan request
//  clear_pressed  in   PADS*BITS  write-1-to-clear mask for pad_pressed
//  pad_data       in   PADS       serial data from each pad; bit p = pad p
//  pad_latch      out  1          latch strobe to all pads
//  pad_clk        out  1          shift clock to all pads; idle low
//  busy           out  1          scan in progress
//  done           out  1          1-cycle pulse when pad_state updates
//  pad_state      out  PADS*BITS  pad p at [p*BITS+:BITS]; bit i = i-th bit shifted
//  pad_pressed    out  PADS*BITS  sticky: bit went 0->1 between consecutive scans
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, FSM IDLE, counters and sync flops 0.
//  - pad_data passes through a 2-flop synchroniser; all sampling uses the synced value.
//  - FSM states: IDLE -> LATCH -> CLK_LO -> CLK_HI -> (CLK_LO | DONE) -> IDLE.
//  - IDLE: go to LATCH on start=1, or when auto-poll timer reaches POLL_INTERVAL.
//    busy=1 in every state except IDLE.
//  - LATCH: pad_latch=1 for 2*HALF_PERIOD cycles; bit index cleared to 0.
//  - CLK_LO: pad_clk=0 for HALF_PERIOD cycles; in the last cycle, sample synced pad_data[p]
//    into shift bit [idx] of pad p (XOR INVERT).
//  - CLK_HI: pad_clk=1 for HALF_PERIOD cycles. Exit: to CLK_LO with idx+1 if idx<BITS-1,
//    else to DONE. Exactly BITS rising pad_clk edges per scan.
//  - DONE (1 cycle): pad_state <= shift; pad_pressed |= shift & ~prev_state; done=1.
//    Then IDLE. prev_state is the pad_state of the previous scan; it is 0 after reset.
//  - Scan length: (2+2*BITS)*HALF_PERIOD + 1 cycles from leaving IDLE to done.
//    Defaults: 105 cycles.
//  - pad_state is stable between done pulses; no partial scan is ever visible.
//  - clear_pressed clears matching pad_pressed bits in any state.
//    Same-cycle set in DONE and clear of one bit: set wins.
//  - start while busy is ignored; it is not queued.
//  - Auto-poll timer: counts IDLE cycles only, resets on leaving IDLE.
//    start and timer expiry in the same cycle start one scan.
//  - Reset mid-scan aborts the scan; pad_state keeps no stale partial data (it is 0).
//  - Counters: phase counter sized for 2*HALF_PERIOD; idx is clog2(BITS) wide;
//    poll timer is 32 bits.
// TESTING
//  1. Default params, 2-pad shift-register models loaded with 12'h5a5 / 12'hc2c on
//     rising pad_latch, shifting on pad_clk rise; start -> done after 105 cycles,
//     pad_state={12'hc2c,12'h5a5}.
//  2. Same bench: count pad_latch high = 8 cycles, exactly 12 pad_clk rising edges,
//     busy high throughout, pad_clk low when idle.
//  3. Second scan with P1=12'h5a7 -> pad_pressed[1]=1 only (plus first-scan bits).
//     clear_pressed=all ones -> 0. Assert clear and set of one bit in DONE
//     -> bit stays 1.
//  4. POLL_INTERVAL=50: done pulses repeat every 105+50 cycles with no start.
//     Extra start pulses while busy do not add scans.
//  5. resetb low at cycle 40 of a scan -> all outputs 0 immediately.
//     After release, start gives a full correct scan.
//  6. PADS=4, BITS=16, INVERT=1, pads 16'h0001/16'h8000/16'hffff/16'h1234 driven
//     active-low -> pad_state matches the true values.

Source files
------------

// File: rtl/gamepad_reader_multi.sv
// ---------------------------------------------------------------------------
// gamepad_reader_multi
//
// Serial gamepad reader for up to four pads that share one latch strobe and
// one shift clock. A scan pulses pad_latch, then clocks BITS bits out of every
// pad at once. Each pad's bits are collected into its own slice of a shift
// register. When the scan completes, the result is published as pad_state,
// and bits that rose 0->1 since the previous scan are OR-ed into the sticky
// pad_pressed flags.
//
// Ports
//   clk            system clock
//   resetb         asynchronous reset, active-low
//   start          one-cycle scan request (only honoured while idle)
//   clear_pressed  write-1-to-clear mask for pad_pressed
//   pad_data       serial data from each pad, bit p = pad p (asynchronous)
//   pad_latch      latch strobe to all pads
//   pad_clk        shift clock to all pads, idle low
//   busy           scan in progress
//   done           one-cycle pulse in the cycle pad_state is loaded
//   pad_state      pad p at [p*BITS +: BITS], bit i = i-th bit shifted out
//   pad_pressed    sticky newly-pressed flags, same layout as pad_state
//   dbg_state      current FSM state, for observation only
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE;
// a request made while busy is dropped, not queued. The done pulse coincides
// with the clock edge that loads pad_state/pad_pressed. The new values are
// therefore visible from the cycle after done onward.
// ---------------------------------------------------------------------------
module gamepad_reader_multi #(
    parameter int PADS          = 2,
    parameter int BITS          = 12,
    parameter int HALF_PERIOD   = 4,
    parameter int POLL_INTERVAL = 0,
    parameter int INVERT        = 0
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 start,
    input  logic [PADS*BITS-1:0] clear_pressed,
    input  logic [PADS-1:0]      pad_data,
    output logic                 pad_latch,
    output logic                 pad_clk,
    output logic                 busy,
    output logic                 done,
    output logic [PADS*BITS-1:0] pad_state,
    output logic [PADS*BITS-1:0] pad_pressed,
    output logic [2:0]           dbg_state
);

    // The phase counter has to reach 2*HALF_PERIOD-1, which is the length
    // of the LATCH phase.
    localparam int   PH_W      = $clog2(2 * HALF_PERIOD);
    localparam int   IDX_W     = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int   W         = PADS * BITS;
    localparam logic INV_BIT   = (INVERT != 0);
    localparam logic AUTO_POLL = (POLL_INTERVAL != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_LO = 3'd2,
        CLK_HI = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       poll_q, poll_d;
    logic [W-1:0]      shift_q, shift_d;
    logic [W-1:0]      pad_state_q, pad_state_d;
    logic [W-1:0]      pad_pressed_q, pad_pressed_d;
    logic [PADS-1:0]   sync1_q, sync2_q;
    logic              poll_expired;

    // The timer holds the number of IDLE cycles already spent. The scan
    // launches in the cycle where that count would reach POLL_INTERVAL.
    // This leaves exactly POLL_INTERVAL idle cycles between scans.
    assign poll_expired = AUTO_POLL && (poll_q == 32'(POLL_INTERVAL - 1));

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        idx_d         = idx_q;
        poll_d        = '0;
        shift_d       = shift_q;
        pad_state_d   = pad_state_q;
        pad_pressed_d = pad_pressed_q & ~clear_pressed;

        case (state_q)
            IDLE: begin
                poll_d = AUTO_POLL ? (poll_q + 32'd1) : 32'd0;
                if (start || poll_expired) begin
                    state_d = LATCH;
                    phase_d = '0;
                    poll_d  = '0;
                end
            end

            LATCH: begin
                idx_d   = '0;
                shift_d = '0;
                if (phase_q == PH_W'(2 * HALF_PERIOD - 1)) begin
                    phase_d = '0;
                    state_d = CLK_LO;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            CLK_LO: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    // Sample as late as possible in the low phase. This gives
                    // the pads the longest settling time after the previous
                    // rising edge plus the synchroniser delay.
                    for (int p = 0; p < PADS; p++) begin
                        for (int i = 0; i < BITS; i++) begin
                            if (IDX_W'(i) == idx_q) begin
                                shift_d[p*BITS + i] = sync2_q[p] ^ INV_BIT;
                            end
                        end
                    end
                    phase_d = '0;
                    state_d = CLK_HI;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            CLK_HI: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    phase_d = '0;
                    if (idx_q == IDX_W'(BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CLK_LO;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            DONE: begin
                // A set from this scan overrides a clear arriving in the same
                // cycle, so a fresh press is never lost.
                pad_state_d   = shift_q;
                pad_pressed_d = (pad_pressed_q & ~clear_pressed)
                              | (shift_q & ~pad_state_q);
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            idx_q         <= '0;
            poll_q        <= '0;
            shift_q       <= '0;
            pad_state_q   <= '0;
            pad_pressed_q <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            poll_q        <= poll_d;
            shift_q       <= shift_d;
            pad_state_q   <= pad_state_d;
            pad_pressed_q <= pad_pressed_d;
            sync1_q       <= pad_data;
            sync2_q       <= sync1_q;
        end
    end

    // All strobes decode straight from the state register. In reset the
    // state is IDLE, so every strobe is low immediately.
    assign pad_latch   = (state_q == LATCH);
    assign pad_clk     = (state_q == CLK_HI);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign pad_state   = pad_state_q;
    assign pad_pressed = pad_pressed_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gamepad_reader_multi.sv
module tb_gamepad_reader_multi;

  logic clk = 1'b0;
  logic resetb;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance: default parameters ----------------
  logic        m_start;
  logic [23:0] m_clear;
  logic [1:0]  m_data;
  logic        m_latch, m_pclk, m_busy, m_done;
  logic [23:0] m_state, m_pressed;
  logic [2:0]  m_dbg;
  logic [11:0] m_val [2];
  logic [11:0] m_sr [2];

  gamepad_reader_multi dut (
    .clk(clk), .resetb(resetb), .start(m_start), .clear_pressed(m_clear),
    .pad_data(m_data), .pad_latch(m_latch), .pad_clk(m_pclk), .busy(m_busy),
    .done(m_done), .pad_state(m_state), .pad_pressed(m_pressed), .dbg_state(m_dbg)
  );

  always @(posedge m_latch or posedge m_pclk) begin
    if (m_latch) begin
      m_sr[0] = m_val[0];
      m_sr[1] = m_val[1];
    end else begin
      m_sr[0] = m_sr[0] >> 1;
      m_sr[1] = m_sr[1] >> 1;
    end
  end
  assign m_data = {m_sr[1][0], m_sr[0][0]};

  // ---------------- auto-poll instance ----------------
  logic        p_start;
  logic [23:0] p_clear;
  logic [1:0]  p_data;
  logic        p_latch, p_pclk, p_busy, p_done;
  logic [23:0] p_state, p_pressed;
  logic [2:0]  p_dbg;
  logic [11:0] p_sr [2];

  gamepad_reader_multi #(.POLL_INTERVAL(50)) dut_poll (
    .clk(clk), .resetb(resetb), .start(p_start), .clear_pressed(p_clear),
    .pad_data(p_data), .pad_latch(p_latch), .pad_clk(p_pclk), .busy(p_busy),
    .done(p_done), .pad_state(p_state), .pad_pressed(p_pressed), .dbg_state(p_dbg)
  );

  always @(posedge p_latch or posedge p_pclk) begin
    if (p_latch) begin
      p_sr[0] = 12'h321;
      p_sr[1] = 12'h0f0;
    end else begin
      p_sr[0] = p_sr[0] >> 1;
      p_sr[1] = p_sr[1] >> 1;
    end
  end
  assign p_data = {p_sr[1][0], p_sr[0][0]};

  // ---------------- wide, active-low instance ----------------
  logic        w_start;
  logic [63:0] w_clear;
  logic [3:0]  w_data;
  logic        w_latch, w_pclk, w_busy, w_done;
  logic [63:0] w_state, w_pressed;
  logic [2:0]  w_dbg;
  logic [15:0] w_val [4];
  logic [15:0] w_sr [4];

  gamepad_reader_multi #(.PADS(4), .BITS(16), .INVERT(1)) dut_wide (
    .clk(clk), .resetb(resetb), .start(w_start), .clear_pressed(w_clear),
    .pad_data(w_data), .pad_latch(w_latch), .pad_clk(w_pclk), .busy(w_busy),
    .done(w_done), .pad_state(w_state), .pad_pressed(w_pressed), .dbg_state(w_dbg)
  );

  always @(posedge w_latch or posedge w_pclk) begin
    for (int p = 0; p < 4; p++) begin
      if (w_latch) w_sr[p] = w_val[p];
      else         w_sr[p] = w_sr[p] >> 1;
    end
  end
  // Pads drive active-low lines.
  assign w_data = ~{w_sr[3][0], w_sr[2][0], w_sr[1][0], w_sr[0][0]};

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the main instance: {pressed, state} per expected scan.
  logic [47:0] m_exp_q[$];

  always @(negedge clk) begin
    if (m_done) begin
      if (m_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL m_unexpected_done: got done at cycle %0d expected no scan", cyc);
      end else begin
        logic [47:0] e;
        e = m_exp_q.pop_front();
        @(posedge clk);
        #1;
        check("m_pad_state", 128'(m_state), 128'(e[23:0]));
        check("m_pad_pressed", 128'(m_pressed), 128'(e[47:24]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic m_scan(input logic [11:0] v0, input logic [11:0] v1,
                        input logic [47:0] exp, input logic [23:0] clr_in_done,
                        input bit extra_start);
    int n, latch_n, rises, busy_low;
    logic prev_clk;
    m_val[0] = v0;
    m_val[1] = v1;
    m_exp_q.push_back(exp);
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    n = 1; latch_n = 0; rises = 0; busy_low = 0; prev_clk = 1'b0;
    while (!m_done && n < 400) begin
      if (m_latch) latch_n++;
      if (m_pclk && !prev_clk) rises++;
      prev_clk = m_pclk;
      if (!m_busy) busy_low++;
      m_start = (extra_start && n == 30);
      @(negedge clk);
      n++;
    end
    m_start = 1'b0;
    check("m_latency", 128'(n), 128'(105));
    check("m_latch_cycles", 128'(latch_n), 128'(8));
    check("m_clk_rises", 128'(rises), 128'(12));
    check("m_busy_low_in_scan", 128'(busy_low), 128'(0));
    if (clr_in_done != 24'h0) m_clear = clr_in_done;
    @(negedge clk);
    m_clear = '0;
    check("m_idle_after", 128'({m_busy, m_pclk, m_latch}), 128'(0));
  endtask

  task automatic w_scan(input logic [63:0] vals, input logic [63:0] exp_state,
                        input logic [63:0] exp_pressed);
    int n;
    for (int p = 0; p < 4; p++) w_val[p] = vals[p*16 +: 16];
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    n = 1;
    while (!w_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("w_latency", 128'(n), 128'(137));
    @(posedge clk);
    #1;
    check("w_pad_state", 128'(w_state), 128'(exp_state));
    check("w_pad_pressed", 128'(w_pressed), 128'(exp_pressed));
    check("w_dbg_idle", 128'(w_dbg), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, guard, t [4];
    int dn;
    resetb = 1'b0;
    m_start = 0; p_start = 0; w_start = 0;
    m_clear = '0; p_clear = '0; w_clear = '0;
    m_val[0] = '0; m_val[1] = '0;
    for (int p = 0; p < 4; p++) w_val[p] = '0;

    repeat (3) @(negedge clk);
    check("rst_main_outputs", 128'({m_latch, m_pclk, m_busy, m_done, m_state, m_pressed, m_dbg}), 128'(0));
    check("rst_poll_outputs", 128'({p_latch, p_pclk, p_busy, p_done, p_state, p_pressed, p_dbg}), 128'(0));
    check("rst_wide_outputs", 128'({w_latch, w_pclk, w_busy, w_done, w_dbg}), 128'(0));
    resetb = 1'b1;
    @(negedge clk);
    check("m_idle_after_reset", 128'({m_busy, m_pclk, m_latch, m_done}), 128'(0));

    // Basic scan, then a press on pad 0 bit 1.
    m_scan(12'h5a5, 12'hc2c, {24'hc2c5a5, 24'hc2c5a5}, 24'h0, 1'b0);
    m_scan(12'h5a7, 12'hc2c, {24'hc2c5a7, 24'hc2c5a7}, 24'h0, 1'b0);

    // Clear all sticky flags while idle.
    @(negedge clk); m_clear = '1;
    @(negedge clk); m_clear = '0;
    check("m_clear_all", 128'(m_pressed), 128'(0));

    // Pad 1 bit 0 rises; clear-all during DONE must not drop the new press.
    m_scan(12'h5a5, 12'hc2d, {24'h001000, 24'hc2d5a5}, 24'hffffff, 1'b0);

    // New presses accumulate; extra start mid-scan is ignored.
    m_scan(12'hfff, 12'h000, {24'h001a5a, 24'h000fff}, 24'h0, 1'b1);
    dn = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    check("m_no_queued_scan", 128'(dn), 128'(0));

    // Reset in cycle 40 of a scan.
    m_val[0] = 12'h0ff; m_val[1] = 12'hf00;
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    repeat (39) @(negedge clk);
    check("m_busy_before_reset", 128'(m_busy), 128'(1));
    resetb = 1'b0;
    #1;
    check("m_reset_midscan", 128'({m_latch, m_pclk, m_busy, m_done, m_state, m_pressed}), 128'(0));
    @(negedge clk);
    resetb = 1'b1;
    m_scan(12'h5a5, 12'hc2c, {24'hc2c5a5, 24'hc2c5a5}, 24'h0, 1'b0);

    // Auto-poll: done every 155 cycles; starts while busy add nothing.
    cnt = 0; guard = 0;
    while (cnt < 4 && guard < 1000) begin
      @(negedge clk);
      guard++;
      p_start = p_busy && !p_done && ($urandom_range(0, 3) == 0);
      if (p_done) begin
        t[cnt] = cyc;
        cnt++;
      end
    end
    p_start = 1'b0;
    check("p_pulse_count", 128'(cnt), 128'(4));
    for (int i = 0; i < 3; i++) check("p_interval", 128'(t[i+1] - t[i]), 128'(155));
    @(negedge clk);
    check("p_pad_state", 128'(p_state), 128'(24'h0f0321));
    check("p_pad_pressed", 128'(p_pressed), 128'(24'h0f0321));

    // Wide, active-low pads.
    w_scan({16'h1234, 16'hffff, 16'h8000, 16'h0001},
           {16'h1234, 16'hffff, 16'h8000, 16'h0001},
           {16'h1234, 16'hffff, 16'h8000, 16'h0001});
    w_scan({16'h1234, 16'hffff, 16'h0000, 16'ha5a5},
           {16'h1234, 16'hffff, 16'h0000, 16'ha5a5},
           {16'h1234, 16'hffff, 16'h8000, 16'ha5a5});

    repeat (5) @(negedge clk);
    check("m_scoreboard_drained", 128'(m_exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
